// File: rtl/app_mon_pkg.sv
// rtl/app_mon_pkg.sv - shared types and default widths for the multiplier error monitor
package app_mon_pkg;

  localparam int DEF_WIDTH1  = 8;
  localparam int DEF_WIDTH2  = 8;
  localparam int DEF_LATENCY = 1;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_ACC_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } mon_state_t;

  // Delay-line entry at the default operand widths; the monitor packs {A,B} the same way.
  typedef struct packed {
    logic                  valid;
    logic [DEF_WIDTH1-1:0] a;
    logic [DEF_WIDTH2-1:0] b;
  } dl_entry_t;

endpackage

// File: rtl/app_mult_err_monitor_if.sv
// rtl/app_mult_err_monitor_if.sv - operand/result bus shared with the multiplier under test
interface app_mult_err_monitor_if #(
  parameter int WIDTH1 = 8,
  parameter int WIDTH2 = 8
);

  logic                     en;
  logic [WIDTH1-1:0]        A;
  logic [WIDTH2-1:0]        B;
  logic [WIDTH1+WIDTH2-1:0] sum;

  modport master (output en, A, B, sum);
  modport slave  (input  en, A, B, sum);

endinterface

// File: rtl/app_mon_delay.sv
// rtl/app_mon_delay.sv - LATENCY-stage valid+data shift register with async active-high clear
module app_mon_delay #(
  parameter int LATENCY = 1,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              pending
);

  logic [LATENCY-1:0] vld;
  logic [DATA_W-1:0]  dat [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_data  = dat[LATENCY-1];

  // Entries still in flight behind the output stage; the line drains once this drops.
  generate
    if (LATENCY > 1) begin : g_pend
      assign pending = |vld[LATENCY-2:0];
    end else begin : g_nopend
      assign pending = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/app_mult_err_monitor.sv
// rtl/app_mult_err_monitor.sv - compares multiplier results with exact products and accumulates error stats
// Optional first-mismatch capture outputs enabled by APP_MON_CAPTURE_EN.
module app_mult_err_monitor
  import app_mon_pkg::*;
#(
  parameter int WIDTH1  = DEF_WIDTH1,
  parameter int WIDTH2  = DEF_WIDTH2,
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_samples,
  app_mult_err_monitor_if.slave    op,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         sample_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [WIDTH1+WIDTH2-1:0] max_ed,
  output logic [ACC_W-1:0]         sum_ed
`ifdef APP_MON_CAPTURE_EN
  ,
  output logic                     cap_valid,
  output logic [WIDTH1-1:0]        cap_A,
  output logic [WIDTH2-1:0]        cap_B,
  output logic [WIDTH1+WIDTH2-1:0] cap_sum
`endif
);

  localparam int PW = WIDTH1 + WIDTH2;
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

  mon_state_t        state, state_nxt;
  logic [CNT_W-1:0]  target, issued, issued_inc;
  logic              start_ok, push;
  logic              out_valid, pending;
  logic [PW-1:0]     out_data;
  logic [WIDTH1-1:0] out_a;
  logic [WIDTH2-1:0] out_b;
  logic [PW-1:0]     exact, ed;
  logic [SW-1:0]     acc_sum;

  assign start_ok   = (state == IDLE) && start;
  assign push       = (state == RUN) && op.en;
  assign issued_inc = issued + CNT_W'(1);

  app_mon_delay #(
    .LATENCY (LATENCY),
    .DATA_W  (PW)
  ) u_delay (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .in_valid  (push),
    .in_data   ({op.A, op.B}),
    .out_valid (out_valid),
    .out_data  (out_data),
    .pending   (pending)
  );

  assign out_a   = out_data[PW-1:WIDTH2];
  assign out_b   = out_data[WIDTH2-1:0];
  assign exact   = PW'(out_a) * PW'(out_b);
  assign ed      = (op.sum >= exact) ? (op.sum - exact) : (exact - op.sum);
  assign acc_sum = SW'(sum_ed) + SW'(ed);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // DRAIN leaves on the edge that compares the last entry, so done lines up with the final update.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_samples == '0) ? DONE : RUN;
      RUN:     if (op.en && (issued_inc == target)) state_nxt = DRAIN;
      DRAIN:   if (!pending) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      target     <= '0;
      issued     <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      max_ed     <= '0;
      sum_ed     <= '0;
    end else if (start_ok) begin
      target     <= num_samples;
      issued     <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      max_ed     <= '0;
      sum_ed     <= '0;
    end else begin
      if (push) issued <= issued_inc;
      if (out_valid) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        if (ed != '0)    err_cnt <= err_cnt + CNT_W'(1);
        if (ed > max_ed) max_ed  <= ed;
        if (|acc_sum[SW-1:ACC_W]) sum_ed <= {ACC_W{1'b1}};
        else                      sum_ed <= acc_sum[ACC_W-1:0];
      end
    end
  end

`ifdef APP_MON_CAPTURE_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cap_valid <= 1'b0;
      cap_A     <= '0;
      cap_B     <= '0;
      cap_sum   <= '0;
    end else if (start_ok) begin
      cap_valid <= 1'b0;
      cap_A     <= '0;
      cap_B     <= '0;
      cap_sum   <= '0;
    end else if (out_valid && (ed != '0) && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_A     <= out_a;
      cap_B     <= out_b;
      cap_sum   <= op.sum;
    end
  end
`endif

endmodule

// File: tb/tb_app_mult_err_monitor.sv
// tb/tb_app_mult_err_monitor.sv - directed self-checking bench for app_mult_err_monitor
module tb_app_mult_err_monitor;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [15:0] num_samples;
  logic        busy, done;
  logic [15:0] sample_cnt, err_cnt, max_ed;
  logic [31:0] sum_ed;
`ifdef APP_MON_CAPTURE_EN
  logic        cap_valid;
  logic [7:0]  cap_A, cap_B;
  logic [15:0] cap_sum;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  app_mult_err_monitor_if #(.WIDTH1(8), .WIDTH2(8)) op ();

  app_mult_err_monitor #(
    .WIDTH1(8), .WIDTH2(8), .LATENCY(1), .CNT_W(16), .ACC_W(32)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .start       (start),
    .num_samples (num_samples),
    .op          (op),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .max_ed      (max_ed),
    .sum_ed      (sum_ed)
`ifdef APP_MON_CAPTURE_EN
    ,
    .cap_valid   (cap_valid),
    .cap_A       (cap_A),
    .cap_B       (cap_B),
    .cap_sum     (cap_sum)
`endif
  );

  // Drives one operand cycle; resp is the multiplier result presented one cycle later.
  task automatic step(input logic e, input logic [7:0] a, input logic [7:0] b, input logic [15:0] resp);
    op.en = e; op.A = a; op.B = b;
    @(posedge sys_clk); #1;
    op.en = 1'b0; op.sum = resp;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1; num_samples = n;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    sys_rst = 1'b1; start = 1'b0; num_samples = '0;
    op.en = 1'b0; op.A = '0; op.B = '0; op.sum = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl: busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if ({sample_cnt, err_cnt, max_ed, sum_ed} !== 80'd0) begin
      failures++; $display("FAIL reset_stats: sc=%0d ec=%0d max=%0d sum=%0d expected all 0", sample_cnt, err_cnt, max_ed, sum_ed);
    end
`ifdef APP_MON_CAPTURE_EN
    checks++;
    if ({cap_valid, cap_A, cap_B, cap_sum} !== 33'd0) begin
      failures++; $display("FAIL reset_cap: valid=%b A=%0d B=%0d sum=%0d expected 0", cap_valid, cap_A, cap_B, cap_sum);
    end
`endif
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_exact;
    do_start(16'd4);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL exact_busy: busy=%b done=%b expected 1 0", busy, done);
    end
    step(1'b1, 8'd3, 8'd5, 16'd15);
    step(1'b1, 8'd255, 8'd255, 16'd65025);
    step(1'b1, 8'd0, 8'd77, 16'd0);
    step(1'b1, 8'd128, 8'd2, 16'd256);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL exact_drain: busy=%b done=%b expected 1 0", busy, done);
    end
    @(posedge sys_clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL exact_done: done=%b busy=%b expected 1 0", done, busy);
    end
    checks++;
    if ({sample_cnt, err_cnt, max_ed, sum_ed} !== {16'd4, 16'd0, 16'd0, 32'd0}) begin
      failures++; $display("FAIL exact_stats: sc=%0d ec=%0d max=%0d sum=%0d expected 4 0 0 0", sample_cnt, err_cnt, max_ed, sum_ed);
    end
    @(posedge sys_clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL exact_pulse: done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_errors;
    do_start(16'd3);
    step(1'b1, 8'd200, 8'd100, 16'd19968);
    step(1'b1, 8'd3, 8'd5, 16'd15);
    step(1'b1, 8'd1, 8'd1, 16'd5);
    @(posedge sys_clk); #1;
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL err_done: done=%b expected 1", done);
    end
    checks++;
    if ({sample_cnt, err_cnt, max_ed, sum_ed} !== {16'd3, 16'd2, 16'd32, 32'd36}) begin
      failures++; $display("FAIL err_stats: sc=%0d ec=%0d max=%0d sum=%0d expected 3 2 32 36", sample_cnt, err_cnt, max_ed, sum_ed);
    end
    @(posedge sys_clk); #1;
  endtask

`ifdef APP_MON_CAPTURE_EN
  task automatic test_capture;
    do_start(16'd4);
    checks++;
    if (cap_valid !== 1'b0) begin
      failures++; $display("FAIL cap_clear: cap_valid=%b expected 0", cap_valid);
    end
    step(1'b1, 8'd1, 8'd2, 16'd2);
    step(1'b1, 8'd10, 8'd10, 16'd96);
    step(1'b1, 8'd3, 8'd3, 16'd9);
    step(1'b1, 8'd7, 8'd7, 16'd50);
    @(posedge sys_clk); #1;
    checks++;
    if ({cap_valid, cap_A, cap_B, cap_sum} !== {1'b1, 8'd10, 8'd10, 16'd96}) begin
      failures++; $display("FAIL cap_first: valid=%b A=%0d B=%0d sum=%0d expected 1 10 10 96", cap_valid, cap_A, cap_B, cap_sum);
    end
    checks++;
    if (err_cnt !== 16'd2 || done !== 1'b1) begin
      failures++; $display("FAIL cap_stats: ec=%0d done=%b expected 2 1", err_cnt, done);
    end
    @(posedge sys_clk); #1;
  endtask
`endif

  task automatic test_gaps;
    do_start(16'd3);
    step(1'b1, 8'd2, 8'd3, 16'd6);
    step(1'b0, 8'd0, 8'd0, 16'd0);
    step(1'b0, 8'd0, 8'd0, 16'd0);
    step(1'b1, 8'd4, 8'd5, 16'd20);
    step(1'b0, 8'd0, 8'd0, 16'd0);
    step(1'b0, 8'd0, 8'd0, 16'd0);
    step(1'b1, 8'd6, 8'd7, 16'd42);
    op.en = 1'b1; op.A = 8'd9; op.B = 8'd9;
    @(posedge sys_clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sample_cnt !== 16'd3) begin
      failures++; $display("FAIL gaps_done: done=%b busy=%b sc=%0d expected 1 0 3", done, busy, sample_cnt);
    end
    @(posedge sys_clk); #1;
    op.en = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sample_cnt !== 16'd3 || err_cnt !== 16'd0) begin
      failures++; $display("FAIL gaps_overrun: done=%b busy=%b sc=%0d ec=%0d expected 0 0 3 0", done, busy, sample_cnt, err_cnt);
    end
  endtask

  task automatic test_zero;
    do_start(16'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL zero_done: done=%b busy=%b expected 1 0", done, busy);
    end
    checks++;
    if ({sample_cnt, err_cnt, max_ed, sum_ed} !== 80'd0) begin
      failures++; $display("FAIL zero_stats: sc=%0d ec=%0d max=%0d sum=%0d expected all 0", sample_cnt, err_cnt, max_ed, sum_ed);
    end
    @(posedge sys_clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL zero_pulse: done=%b expected 0", done);
    end
  endtask

  task automatic test_busy_start;
    do_start(16'd3);
    step(1'b1, 8'd1, 8'd1, 16'd1);
    start = 1'b1; num_samples = 16'd1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || sample_cnt !== 16'd1) begin
      failures++; $display("FAIL busy_start_run: busy=%b sc=%0d expected 1 1", busy, sample_cnt);
    end
    step(1'b1, 8'd2, 8'd2, 16'd4);
    step(1'b1, 8'd3, 8'd3, 16'd9);
    @(posedge sys_clk); #1;
    checks++;
    if (done !== 1'b1 || sample_cnt !== 16'd3 || err_cnt !== 16'd0) begin
      failures++; $display("FAIL busy_start_done: done=%b sc=%0d ec=%0d expected 1 3 0", done, sample_cnt, err_cnt);
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_reset_mid;
    do_start(16'd5);
    step(1'b1, 8'd4, 8'd4, 16'd20);
    step(1'b1, 8'd2, 8'd2, 16'd9);
    @(posedge sys_clk); #1;
    checks++;
    if ({sample_cnt, err_cnt, max_ed, sum_ed} !== {16'd2, 16'd2, 16'd5, 32'd9} || busy !== 1'b1) begin
      failures++; $display("FAIL mid_pre: sc=%0d ec=%0d max=%0d sum=%0d busy=%b expected 2 2 5 9 1", sample_cnt, err_cnt, max_ed, sum_ed, busy);
    end
    sys_rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, sample_cnt, err_cnt, max_ed, sum_ed} !== 82'd0) begin
      failures++; $display("FAIL mid_reset: busy=%b done=%b sc=%0d ec=%0d max=%0d sum=%0d expected all 0", busy, done, sample_cnt, err_cnt, max_ed, sum_ed);
    end
    #2;
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    do_start(16'd2);
    step(1'b1, 8'd5, 8'd6, 16'd30);
    step(1'b1, 8'd9, 8'd9, 16'd81);
    @(posedge sys_clk); #1;
    checks++;
    if (done !== 1'b1 || sample_cnt !== 16'd2 || err_cnt !== 16'd0 || sum_ed !== 32'd0) begin
      failures++; $display("FAIL mid_restart: done=%b sc=%0d ec=%0d sum=%0d expected 1 2 0 0", done, sample_cnt, err_cnt, sum_ed);
    end
    @(posedge sys_clk); #1;
  endtask

  initial begin
    test_reset;
    test_exact;
    test_errors;
`ifdef APP_MON_CAPTURE_EN
    test_capture;
`endif
    test_gaps;
    test_zero;
    test_busy_start;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
